// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - five-channel push-button synchroniser, debouncer and edge pulser
// Define BTN_AUTOREPEAT_EN to add press auto-repeat while a button is held.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       up,
   input  logic       down,
   input  logic       left,
   input  logic       right,
   input  logic       centre,
   output logic [4:0] btn_level,
   output logic [4:0] btn_press,
   output logic [4:0] btn_release,
   output logic       any_press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW = $clog2(RPT_MAX) + 1;
   localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_PERIOD - 1);
`endif

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } state_t;

   logic [4:0]    raw;
   logic [4:0]    sync1;
   logic [4:0]    sync2;
   logic [4:0]    lvl_q;
   logic [4:0]    prs_q;
   logic [4:0]    rel_q;
   state_t        state [5];
   logic [CW-1:0] cnt   [5];
`ifdef BTN_AUTOREPEAT_EN
   logic [RW-1:0] rpt   [5];
`endif

   assign raw = {centre, right, left, down, up};

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lvl_q <= '0;
         prs_q <= '0;
         rel_q <= '0;
         for (int i = 0; i < 5; i++) begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
`ifdef BTN_AUTOREPEAT_EN
            rpt[i]   <= '0;
`endif
         end
      end else begin
         for (int i = 0; i < 5; i++) begin
            prs_q[i] <= 1'b0;
            rel_q[i] <= 1'b0;
            case (state[i])
               IDLE: begin
                  if (sync2[i]) begin
                     state[i] <= PRESS_WAIT;
                     cnt[i]   <= '0;
                  end
               end
               PRESS_WAIT: begin
                  if (!sync2[i]) begin
                     state[i] <= IDLE;
                  end else if (cnt[i] == CNT_LAST) begin
                     state[i] <= HELD;
                     lvl_q[i] <= 1'b1;
                     prs_q[i] <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                     rpt[i]   <= RPT_FIRST;
`endif
                  end else begin
                     cnt[i] <= cnt[i] + 1'b1;
                  end
               end
               HELD: begin
                  if (!sync2[i]) begin
                     state[i] <= RELEASE_WAIT;
                     cnt[i]   <= '0;
`ifdef BTN_AUTOREPEAT_EN
                  // Repeat countdown freezes in RELEASE_WAIT so a bounce does not restart it.
                  end else if (rpt[i] == '0) begin
                     prs_q[i] <= 1'b1;
                     rpt[i]   <= RPT_NEXT;
                  end else begin
                     rpt[i] <= rpt[i] - 1'b1;
`endif
                  end
               end
               RELEASE_WAIT: begin
                  if (sync2[i]) begin
                     state[i] <= HELD;
                  end else if (cnt[i] == CNT_LAST) begin
                     state[i] <= IDLE;
                     lvl_q[i] <= 1'b0;
                     rel_q[i] <= 1'b1;
                  end else begin
                     cnt[i] <= cnt[i] + 1'b1;
                  end
               end
               default: state[i] <= IDLE;
            endcase
         end
      end
   end

   // Output stage: fixes latency at DEBOUNCE_CYCLES+3 edges from first raw sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_level   <= '0;
         btn_press   <= '0;
         btn_release <= '0;
         any_press   <= 1'b0;
      end else begin
         btn_level   <= lvl_q;
         btn_press   <= prs_q;
         btn_release <= rel_q;
         any_press   <= |prs_q;
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
// Uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
module tb_button_conditioner;

   logic       clk;
   logic       reset;
   logic       up, down, left, right, centre;
   logic [4:0] btn_level;
   logic [4:0] btn_press;
   logic [4:0] btn_release;
   logic       any_press;

   int total = 0;
   int bad   = 0;
   int n_press;
   int n_rel;

   button_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (20),
      .REPEAT_PERIOD  (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .up         (up),
      .down       (down),
      .left       (left),
      .right      (right),
      .centre     (centre),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .btn_release(btn_release),
      .any_press  (any_press)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Tick once, then count pulses on one channel.
   task automatic tick_count(input int ch);
      tick(1);
      if (btn_press[ch])   n_press++;
      if (btn_release[ch]) n_rel++;
   endtask

   initial begin
      reset = 1'b1;
      {up, down, left, right, centre} = '0;
      tick(3);
      check("reset_level", {11'd0, btn_level}, 16'd0);
      check("reset_pulses", {6'd0, btn_press, btn_release}, 16'd0);
      check("reset_any", {15'd0, any_press}, 16'd0);
      reset = 1'b0;
      tick(3);

      // Single press on up: accepted at edge 7
      up = 1'b1;
      tick(7);
      check("up_before_edge7", {6'd0, btn_level, btn_press}, 16'd0);
      tick(1);
      check("up_level_edge7", {11'd0, btn_level}, 16'h0001);
      check("up_press_edge7", {11'd0, btn_press}, 16'h0001);
      check("up_any_edge7", {15'd0, any_press}, 16'd1);
      tick(1);
      check("up_press_oneshot", {11'd0, btn_press}, 16'd0);
      check("up_level_held", {11'd0, btn_level}, 16'h0001);
      up = 1'b0;
      tick(7);
      check("up_rel_before", {11'd0, btn_release}, 16'd0);
      tick(1);
      check("up_release", {6'd0, btn_level, btn_release}, {6'd0, 5'b00000, 5'b00001});
      tick(1);
      check("up_release_oneshot", {11'd0, btn_release}, 16'd0);
      tick(3);

      // Glitch on left shorter than debounce
      left = 1'b1;
      tick(3);
      left = 1'b0;
      n_press = 0;
      for (int k = 0; k < 12; k++) begin
         tick(1);
         if ((btn_level | btn_press | btn_release) != 5'd0) n_press++;
      end
      check("left_glitch_quiet", 16'(n_press), 16'd0);

      // Right held 30 cycles with a bounce on release
      n_press = 0;
      n_rel   = 0;
      right   = 1'b1;
      for (int k = 0; k < 30; k++) tick_count(3);
      check("right_press_count", 16'(n_press), 16'd1);
      check("right_level_held", {11'd0, btn_level}, 16'h0008);
      right = 1'b0;
      tick_count(3);
      right = 1'b1;
      tick_count(3);
      right = 1'b0;
      for (int k = 0; k < 7; k++) tick_count(3);
      check("right_no_early_release", 16'(n_rel), 16'd0);
      tick_count(3);
      check("right_release_edge7", {6'd0, btn_level, btn_release}, {6'd0, 5'b00000, 5'b01000});
      for (int k = 0; k < 6; k++) begin
         tick_count(3);
         check("right_press_rel_exclusive", {15'd0, btn_press[3] & btn_release[3]}, 16'd0);
      end
      check("right_release_count", 16'(n_rel), 16'd1);
      check("right_press_total", 16'(n_press), 16'd1);

      // Reset mid-debounce while centre stays high
      centre = 1'b1;
      tick(5);
      reset = 1'b1;
      tick(1);
      check("rst_mid_outputs1", {5'd0, btn_level, btn_press, any_press}, 16'd0);
      tick(1);
      check("rst_mid_outputs2", {5'd0, btn_level, btn_press, btn_release}, 16'd0);
      reset   = 1'b0;
      n_press = 0;
      n_rel   = 0;
      for (int k = 0; k < 7; k++) tick_count(4);
      check("centre_no_early_press", 16'(n_press), 16'd0);
      tick_count(4);
      check("centre_press_edge7", {11'd0, btn_press}, 16'h0010);
      for (int k = 0; k < 6; k++) tick_count(4);
      check("centre_press_count", 16'(n_press), 16'd1);
      centre = 1'b0;
      tick(12);

      // Up and down together
      up   = 1'b1;
      down = 1'b1;
      tick(7);
      check("updown_before", {11'd0, btn_press}, 16'd0);
      tick(1);
      check("updown_press", {11'd0, btn_press}, 16'h0003);
      check("updown_any", {15'd0, any_press}, 16'd1);
      up   = 1'b0;
      down = 1'b0;
      tick(14);

      // Down held 60 cycles: auto-repeat count depends on build
      n_press = 0;
      n_rel   = 0;
      down    = 1'b1;
      for (int k = 0; k < 60; k++) tick_count(1);
      down = 1'b0;
      for (int k = 0; k < 14; k++) tick_count(1);
`ifdef BTN_AUTOREPEAT_EN
      check("down_repeat_presses", 16'(n_press), 16'd6);
`else
      check("down_single_press", 16'(n_press), 16'd1);
`endif
      check("down_release_count", 16'(n_rel), 16'd1);
      check("final_level", {11'd0, btn_level}, 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples required to accept a level change (10 ms at 100 MHz).
REQ-002 Parameter: REPEAT_DELAY, 50000000, cycles from accepted press to first auto-repeat pulse.
REQ-003 Parameter: REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses.
REQ-004 Port: clk  input  1  system clock; the block uses only this clock.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: up, down, left, right, centre  input  1 each  raw asynchronous push-button levels, active-high.
REQ-007 Port: btn_level  output  5  debounced levels; bit0 up, bit1 down, bit2 left, bit3 right, bit4 centre.
REQ-008 Port: btn_press  output  5  one-cycle press pulses, same bit order.
REQ-009 Port: btn_release  output  5  one-cycle release pulses, same bit order.
REQ-010 Port: any_press  output  1  OR of btn_press bits, same cycle.

Function
REQ-011 Each raw input SHALL pass through two flip-flops (sync1, sync2) before any other logic; channels are fully independent.
REQ-012 Each channel SHALL run a four-state FSM: IDLE (level 0), PRESS_WAIT, HELD (level 1), RELEASE_WAIT.
REQ-013 IDLE: sync2=1 -> PRESS_WAIT with count cleared to 0; else stay.
REQ-014 PRESS_WAIT: sync2=0 -> IDLE; sync2=1 and count=DEBOUNCE_CYCLES-1 -> HELD, btn_level bit set, btn_press bit pulsed for exactly one cycle; otherwise count increments.
REQ-015 HELD: sync2=0 -> RELEASE_WAIT with count cleared; else stay.
REQ-016 RELEASE_WAIT: sync2=1 -> HELD (no pulse); sync2=0 and count=DEBOUNCE_CYCLES-1 -> IDLE, level bit cleared, btn_release bit pulsed for one cycle; otherwise count increments.
REQ-017 Latency: with raw held steady after a change, the registered btn_level/pulse SHALL update exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the new raw value.
REQ-018 Any raw excursion shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no output change.
REQ-019 Counter width SHALL be clog2(DEBOUNCE_CYCLES)+1 bits, saturating semantics irrelevant as it never exceeds DEBOUNCE_CYCLES-1; DEBOUNCE_CYCLES >= 2.
REQ-020 All outputs SHALL be registered; btn_press and btn_release of a channel SHALL never assert in the same cycle.
REQ-021 Simultaneous presses on several channels SHALL each produce their own pulse in the cycle their own debounce completes.

Reset
REQ-022 While reset=1 at a clock edge: sync flops, counters, repeat counters cleared; all FSMs to IDLE; btn_level, btn_press, btn_release, any_press = 0.
REQ-023 Reset mid-debounce SHALL discard the partial count; a button held through reset deassertion SHALL be re-debounced from IDLE and yield one btn_press.

Configuration
REQ-024 Macro BTN_AUTOREPEAT_EN defined: in HELD a repeat counter SHALL emit an additional btn_press pulse REPEAT_DELAY cycles after entering HELD, then every REPEAT_PERIOD cycles while HELD; repeat counter cleared on entering HELD; RELEASE_WAIT->HELD bounce SHALL NOT restart the repeat counter.
REQ-025 Macro BTN_AUTOREPEAT_EN undefined: no repeat logic synthesized; exactly one btn_press per accepted press.

Verification (bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-026 up raised at edge 0, held -> btn_level[0]=1 and btn_press[0]=1 for one cycle at edge 7; any_press=1 same cycle.
REQ-027 left pulsed high for 3 cycles, then low -> btn_level, btn_press, btn_release stay 0 throughout.
REQ-028 right held 30 cycles then released, bounced 1 cycle at release -> single btn_press[3], single btn_release[3] 7 edges after final stable low sample.
REQ-029 reset asserted 2 cycles while centre in PRESS_WAIT with count=2, centre kept high -> all outputs 0 during reset; btn_press[4] once, 7 edges after reset deasserts.
REQ-030 up and down raised same edge -> btn_press[0] and btn_press[1] both pulse at edge 7.
REQ-031 With BTN_AUTOREPEAT_EN, down held 60 cycles -> btn_press[1] pulses at acceptance, +20, +28, +36, ... until release; without macro, one pulse only.
